basemul_zeta_sched: RTL
=======================

BASEMUL_ZETA_SCHED -- requirements
Module: basemul_zeta_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the twiddle-ROM address width (128 entries).
REQ-002 SHALL have parameter LEN_W, default 8, meaning the job-length width (0..128 beats).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a job request pulse, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, a synchronous job cancel.
REQ-007 SHALL have port cfg_base, input, ADDR_W, the first ROM/pair index, captured at start.
REQ-008 SHALL have port cfg_len, input, LEN_W, the number of beats, captured at start; values above 128 are clamped to 128.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port rom_addr, output, ADDR_W, driving the registered twiddle ROM address.
REQ-012 SHALL have port rom_srst, output, 1, driving the ROM synchronous clear.
REQ-013 SHALL have port rom_dout, input, 16, the ROM data (signed 16-bit ±zeta), valid one cycle after its address.
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the beat handshake to the basemul datapath.
REQ-015 SHALL have port out_zeta, output, 16, equal to rom_dout combinationally.
REQ-016 SHALL have port out_pair, output, ADDR_W, the pair index k of the current beat.
REQ-017 SHALL have port out_coef_addr, output, 8, equal to 2*k, the even-coefficient address of the beat.
REQ-018 SHALL have port out_last, output, 1, high on the final beat of the job.

Function
REQ-019 SHALL use the FSM states IDLE, RUN, DRAIN and DONE.
REQ-020 In IDLE with start=1 and a clamped length > 0, the FSM SHALL go to RUN and load the issue index to cfg_base and the remaining count to the length.
REQ-021 In IDLE with start=1 and length = 0, the FSM SHALL go to DONE with no beats issued.
REQ-022 advance SHALL be defined as (!out_valid || out_ready).
REQ-023 In RUN, rom_addr SHALL equal the issue index; on each advance the index SHALL increment modulo 128 (127->0 wrap) and the remaining count SHALL decrement.
REQ-024 When advance is low, rom_addr and all beat registers SHALL hold, so that the ROM re-registers the same word and out_zeta stays stable while stalled.
REQ-025 out_valid SHALL be set on an edge where RUN advances, SHALL hold while out_valid=1 and out_ready=0, and SHALL clear on any other edge.
REQ-026 out_pair and out_last SHALL be registered alongside out_valid so that they align with rom_dout.
REQ-027 When RUN issues its final address, the FSM SHALL go to DRAIN.
REQ-028 In DRAIN, the FSM SHALL go to DONE when the last beat is accepted (out_valid && out_ready && out_last).
REQ-029 The DONE state SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-030 Latency: start sampled at edge t SHALL give the first out_valid in the cycle after edge t+2; with out_ready tied high, throughput SHALL be 1 beat per cycle.
REQ-031 abort in any non-IDLE state SHALL force IDLE and out_valid=0 on the next edge, with no done pulse; abort SHALL take priority over start.
REQ-032 start while busy SHALL be ignored.
REQ-033 rom_srst SHALL be 1 in IDLE and DONE and 0 in RUN and DRAIN.
REQ-034 out_coef_addr SHALL be {out_pair, 1'b0}.

Reset
REQ-035 While rst_n=0, the block SHALL be in IDLE with busy=0, done=0, out_valid=0, out_last=0, out_pair=0, rom_addr=0, rom_srst=1 and all counters 0.
REQ-036 On deassertion of rst_n, the block SHALL accept the first start on the following edge.

Structure
REQ-037 The shared package SHALL hold the FSM state enum, KYBER_N=256, ZETA_ENTRIES=128 and the LEN clamp constant.
REQ-038 A single sub-module SHALL be instantiated: rom_gen_8 (addr=rom_addr, srst=rom_srst, dout=rom_dout), inside the wrapper basemul_zeta_sched_top; the core block itself SHALL contain no sub-modules.

Verification
REQ-039 Full job: base=0, len=128, ready=1 -> 128 beats on consecutive cycles; beat0 zeta=0x08b2, beat1 zeta=0xf74e, beat127 zeta=0xf9a4 with out_last=1; done exactly 1 cycle after the last beat.
REQ-040 Wrap: base=126, len=4 -> out_pair sequence 126,127,0,1; zetas 0x065c, 0xf9a4, 0x08b2, 0xf74e.
REQ-041 Backpressure: random out_ready at 50% -> every beat held stable while stalled; no duplicated or dropped pairs; coef_addr=2*pair throughout.
REQ-042 len=0 -> no out_valid, done one cycle after IDLE exit; len=200 -> exactly 128 beats.
REQ-043 Abort after 10 accepted beats -> out_valid low next cycle, no done pulse, busy low; a new start then runs correctly.
REQ-044 rst_n asserted mid-RUN -> outputs take reset values asynchronously; start while busy is ignored.

Source files
------------

// File: rtl/basemul_zeta_sched_pkg.sv
// Shared types and constants for the basemul twiddle scheduler.
// The zeta table holds the Kyber basemul twiddles zetas[64..127] in
// Montgomery form; ROM entry 2i is +zeta_i and entry 2i+1 is -zeta_i.
package basemul_zeta_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } zeta_state_e;

    localparam int KYBER_N      = 256;
    localparam int ZETA_ENTRIES = 128;
    // Longest job: one beat per ROM entry.
    localparam int LEN_MAX      = ZETA_ENTRIES;
    // Coefficient address width: indexes all KYBER_N coefficients.
    localparam int COEF_W       = $clog2(KYBER_N);

    localparam logic [11:0] ZETA_TAB [64] = '{
        12'd2226, 12'd430,  12'd555,  12'd843,  12'd2078, 12'd871,  12'd1550, 12'd105,
        12'd422,  12'd587,  12'd177,  12'd3094, 12'd3038, 12'd2869, 12'd1574, 12'd1653,
        12'd3083, 12'd778,  12'd1159, 12'd3182, 12'd2552, 12'd1483, 12'd2727, 12'd1119,
        12'd1739, 12'd644,  12'd2457, 12'd349,  12'd418,  12'd329,  12'd3173, 12'd3254,
        12'd817,  12'd1097, 12'd603,  12'd610,  12'd1322, 12'd2044, 12'd1864, 12'd384,
        12'd2114, 12'd3193, 12'd1218, 12'd1994, 12'd2455, 12'd220,  12'd2142, 12'd1670,
        12'd2144, 12'd1799, 12'd2051, 12'd794,  12'd1819, 12'd2475, 12'd2459, 12'd478,
        12'd3221, 12'd3021, 12'd996,  12'd991,  12'd958,  12'd1869, 12'd1522, 12'd1628
    };

    // Signed 16-bit twiddle for ROM index idx (odd entries are negated).
    function automatic logic [15:0] zeta_word(input logic [6:0] idx);
        logic [15:0] mag;
        mag = {4'd0, ZETA_TAB[idx[6:1]]};
        return idx[0] ? (16'd0 - mag) : mag;
    endfunction

endpackage

// File: rtl/basemul_zeta_sched_rom.sv
// rom_gen_8: 128 x 16 synchronous twiddle ROM with synchronous clear.
// dout reflects the address sampled on the previous rising edge.
module rom_gen_8
    import basemul_zeta_sched_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout
);

    // Registered read; srst forces the output word to zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            dout <= '0;
        end else begin
            dout <= zeta_word(7'(addr));
        end
    end

endmodule

// File: rtl/basemul_zeta_sched_top.sv
// Scheduler core plus its twiddle ROM, as seen by the basemul datapath.
module basemul_zeta_sched_top
    import basemul_zeta_sched_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_zeta,
    output logic [ADDR_W-1:0] out_pair,
    output logic [COEF_W-1:0] out_coef_addr,
    output logic              out_last,
    output zeta_state_e       dbg_state
);

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_srst;
    logic [15:0]       rom_dout;

    basemul_zeta_sched #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_base      (cfg_base),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .rom_addr      (rom_addr),
        .rom_srst      (rom_srst),
        .rom_dout      (rom_dout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_zeta      (out_zeta),
        .out_pair      (out_pair),
        .out_coef_addr (out_coef_addr),
        .out_last      (out_last),
        .dbg_state     (dbg_state)
    );

    rom_gen_8 #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk  (clk),
        .srst (rom_srst),
        .addr (rom_addr),
        .dout (rom_dout)
    );

endmodule

// File: rtl/basemul_zeta_sched.sv
// Twiddle scheduler for the Kyber basemul datapath. Walks the zeta ROM from
// cfg_base for cfg_len beats (clamped to 128), presenting one beat per
// accepted handshake with the pair index, coefficient address and zeta.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, out_pair/out_last/out_zeta/out_coef_addr stay
// constant until that transfer; out_valid never drops without a transfer
// except on abort or reset.
module basemul_zeta_sched
    import basemul_zeta_sched_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_srst,
    input  logic [15:0]       rom_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_zeta,
    output logic [ADDR_W-1:0] out_pair,
    output logic [COEF_W-1:0] out_coef_addr,
    output logic              out_last,
    output zeta_state_e       dbg_state
);

    localparam logic [LEN_W-1:0] LEN_CLAMP = LEN_W'(LEN_MAX);

    zeta_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [LEN_W-1:0]  remain_q;
    logic              run_go_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [ADDR_W-1:0] out_pair_q;

    logic [LEN_W-1:0]  len_clamped;
    logic              advance;
    logic              issue;
    logic              last_issue;
    logic              accept_start;
    logic              kill;

    assign len_clamped  = (cfg_len > LEN_CLAMP) ? LEN_CLAMP : cfg_len;
    assign advance      = !out_valid_q || out_ready;
    assign kill         = abort && (state_q != IDLE);
    assign accept_start = (state_q == IDLE) && start && !abort;
    // The first RUN cycle only presents the base address; issuing starts
    // on the following edge.
    assign issue        = (state_q == RUN) && run_go_q && advance && !abort;
    assign last_issue   = issue && (remain_q == LEN_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every non-IDLE transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_start) begin
                    state_d = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (kill) begin
            state_d = IDLE;
        end
    end

    // Issue index and remaining-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            remain_q <= '0;
            run_go_q <= 1'b0;
        end else if (accept_start) begin
            idx_q    <= cfg_base;
            remain_q <= len_clamped;
            run_go_q <= 1'b0;
        end else if (state_q == RUN) begin
            run_go_q <= 1'b1;
            if (issue) begin
                idx_q    <= idx_q + ADDR_W'(1);
                remain_q <= remain_q - LEN_W'(1);
            end
        end
    end

    // Beat registers, aligned with the ROM word latched on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pair_q  <= '0;
        end else if (kill) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (advance) begin
            out_valid_q <= issue;
            out_last_q  <= last_issue;
            if (issue) begin
                out_pair_q <= idx_q;
            end
        end
    end

    // While a beat is stalled the ROM keeps reading that beat's own address,
    // so the re-registered word (and out_zeta) does not change.
    assign rom_addr      = ((state_q == RUN) && advance) ? idx_q : out_pair_q;
    assign rom_srst      = (state_q == IDLE) || (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_pair      = out_pair_q;
    assign out_zeta      = rom_dout;
    assign out_coef_addr = COEF_W'({out_pair_q, 1'b0});
    assign dbg_state     = state_q;

endmodule
